// File: rtl/line_window_ctrl.sv
// Sequencer for a K-line circular line buffer feeding a KxK sliding-window filter.
// Build option LINE_WINDOW_STALL_CNT_EN adds a saturating downstream-stall counter (stall_cnt_o).
module line_window_ctrl #(
    parameter int width_p  = 8,
    parameter int height_p = 6,
    parameter int kernel_p = 3,
    parameter int lines_p  = kernel_p,
    localparam int col_w_lp = $clog2(width_p),
    localparam int row_w_lp = $clog2(height_p),
    localparam int ptr_w_lp = (lines_p <= 1) ? 1 : $clog2(lines_p)
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                valid_i,
    output logic                ready_o,
    output logic                wr_en_o,
    output logic [ptr_w_lp-1:0] wr_row_o,
    output logic [col_w_lp-1:0] wr_col_o,
    output logic                valid_o,
    input  logic                ready_i,
    output logic [ptr_w_lp-1:0] top_row_o,
    output logic [row_w_lp-1:0] row_o,
    output logic [col_w_lp-1:0] col_o,
    output logic                frame_done_o
`ifdef LINE_WINDOW_STALL_CNT_EN
    ,
    output logic [15:0]         stall_cnt_o
`endif
);

    localparam logic [col_w_lp-1:0] col_last_lp = col_w_lp'(width_p - 1);
    localparam logic [col_w_lp-1:0] col_k1_lp   = col_w_lp'(kernel_p - 1);
    localparam logic [row_w_lp-1:0] row_last_lp = row_w_lp'(height_p - 1);
    localparam logic [row_w_lp-1:0] row_k2_lp   = row_w_lp'(kernel_p - 2);
    localparam logic [ptr_w_lp-1:0] ptr_last_lp = ptr_w_lp'(lines_p - 1);
    localparam logic [ptr_w_lp-1:0] ptr_k1_lp   = ptr_w_lp'(kernel_p - 1);
    localparam logic [ptr_w_lp-1:0] ptr_wrap_lp = ptr_w_lp'(lines_p - kernel_p + 1);

    typedef enum logic {FILL, STREAM} state_e;

    state_e              state_r;
    logic [col_w_lp-1:0] col_r;
    logic [row_w_lp-1:0] row_r;
    logic [ptr_w_lp-1:0] wr_ptr_r;

    logic                accept;
    logic                last_col;
    logic                last_pix;
    logic                win_hit;
    logic [ptr_w_lp-1:0] top_row_next;

    // A token can only be popped, so the upstream may push whenever the output slot frees up.
    assign ready_o  = ~valid_o | ready_i;
    assign accept   = valid_i & ready_o;
    assign wr_en_o  = accept;
    assign wr_row_o = wr_ptr_r;
    assign wr_col_o = col_r;

    assign last_col = (col_r == col_last_lp);
    assign last_pix = last_col & (row_r == row_last_lp);
    // STREAM means row_r >= kernel_p-1, so only the column needs checking here.
    assign win_hit  = (state_r == STREAM) & (col_r >= col_k1_lp);

    // Oldest resident line, modulo lines_p, without needing a divider.
    assign top_row_next = (wr_ptr_r >= ptr_k1_lp) ? (wr_ptr_r - ptr_k1_lp)
                                                  : (wr_ptr_r + ptr_wrap_lp);

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r      <= FILL;
            col_r        <= '0;
            row_r        <= '0;
            wr_ptr_r     <= '0;
            valid_o      <= 1'b0;
            row_o        <= '0;
            col_o        <= '0;
            top_row_o    <= '0;
            frame_done_o <= 1'b0;
        end else begin
            frame_done_o <= accept & last_pix;
            if (accept) begin
                valid_o <= win_hit;
                if (win_hit) begin
                    row_o     <= row_r;
                    col_o     <= col_r;
                    top_row_o <= top_row_next;
                end
                if (last_pix) begin
                    col_r    <= '0;
                    row_r    <= '0;
                    wr_ptr_r <= '0;
                    state_r  <= FILL;
                end else if (last_col) begin
                    col_r    <= '0;
                    row_r    <= row_r + row_w_lp'(1);
                    wr_ptr_r <= (wr_ptr_r == ptr_last_lp) ? '0 : wr_ptr_r + ptr_w_lp'(1);
                    if (row_r == row_k2_lp) begin
                        state_r <= STREAM;
                    end
                end else begin
                    col_r <= col_r + col_w_lp'(1);
                end
            end else if (ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end

`ifdef LINE_WINDOW_STALL_CNT_EN
    // The frame_done cycle clears the count and its own stall is dropped.
    always_ff @(posedge clk_i) begin
        if (reset_i || frame_done_o) begin
            stall_cnt_o <= '0;
        end else if (valid_o && !ready_i && (stall_cnt_o != 16'hFFFF)) begin
            stall_cnt_o <= stall_cnt_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_line_window_ctrl.sv
// Directed self-checking bench for line_window_ctrl: default 8x6/K=3 instance plus a 4x5/K=2/L=4 instance.
`timescale 1ns/1ps
module tb_line_window_ctrl;

    localparam int W  = 8, H  = 6, K  = 3, L  = 3, CW  = 3, RW  = 3, PW  = 2;
    localparam int W2 = 4, H2 = 5, K2 = 2, L2 = 4, CW2 = 2, RW2 = 3, PW2 = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_i, valid_i, ready_i;
    logic          ready_o, wr_en_o, valid_o, frame_done_o;
    logic [PW-1:0] wr_row_o, top_row_o;
    logic [CW-1:0] wr_col_o, col_o;
    logic [RW-1:0] row_o;
    logic [15:0]   stall_cnt;

    logic           reset2, valid2, ready2;
    logic           ready2_o, wr_en2_o, valid2_o, frame_done2_o;
    logic [PW2-1:0] wr_row2_o, top_row2_o;
    logic [CW2-1:0] wr_col2_o, col2_o;
    logic [RW2-1:0] row2_o;
    logic [15:0]    stall_cnt2;

    int tests_run = 0;
    int failed    = 0;

    line_window_ctrl dut (
        .clk_i(clk), .reset_i(reset_i), .valid_i(valid_i), .ready_o(ready_o),
        .wr_en_o(wr_en_o), .wr_row_o(wr_row_o), .wr_col_o(wr_col_o),
        .valid_o(valid_o), .ready_i(ready_i), .top_row_o(top_row_o),
        .row_o(row_o), .col_o(col_o), .frame_done_o(frame_done_o)
`ifdef LINE_WINDOW_STALL_CNT_EN
        , .stall_cnt_o(stall_cnt)
`endif
    );

    line_window_ctrl #(.width_p(W2), .height_p(H2), .kernel_p(K2), .lines_p(L2)) dut2 (
        .clk_i(clk), .reset_i(reset2), .valid_i(valid2), .ready_o(ready2_o),
        .wr_en_o(wr_en2_o), .wr_row_o(wr_row2_o), .wr_col_o(wr_col2_o),
        .valid_o(valid2_o), .ready_i(ready2), .top_row_o(top_row2_o),
        .row_o(row2_o), .col_o(col2_o), .frame_done_o(frame_done2_o)
`ifdef LINE_WINDOW_STALL_CNT_EN
        , .stall_cnt_o(stall_cnt2)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
        tick(); tick();
        reset_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_i = 1'b1; valid_i = 1'b1; ready_i = 1'b0;
        tick(); tick();
        tests_run++;
        if (valid_o !== 1'b0 || frame_done_o !== 1'b0 || row_o !== '0 || col_o !== '0 || top_row_o !== '0) begin
            failed++;
            $display("FAIL reset_outputs: got v=%b fd=%b r=%0d c=%0d t=%0d, want all 0",
                     valid_o, frame_done_o, row_o, col_o, top_row_o);
        end
        reset_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
        #1;
        tests_run++;
        if (ready_o !== 1'b1 || wr_en_o !== 1'b0 || wr_row_o !== '0 || wr_col_o !== '0) begin
            failed++;
            $display("FAIL reset_wr_side: got rdy=%b we=%b row=%0d col=%0d, want 1 0 0 0",
                     ready_o, wr_en_o, wr_row_o, wr_col_o);
        end
`ifdef LINE_WINDOW_STALL_CNT_EN
        tests_run++;
        if (stall_cnt !== 16'd0) begin
            failed++;
            $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt);
        end
`endif
        tick();
    endtask

    // One full frame, ready_i=1: write addresses, tokens, top_row and frame_done per cycle.
    task automatic test_frame();
        int ntok = 0, first = -1;
        int r, c, pr, pc;
        bit ptok;
        do_reset();
        for (int i = 0; i <= W*H; i++) begin
            valid_i = (i < W*H); ready_i = 1'b1;
            #1;
            if (i < W*H) begin
                r = i / W; c = i % W;
                tests_run++;
                if (wr_en_o !== 1'b1 || wr_row_o !== PW'(r % L) || wr_col_o !== CW'(c)) begin
                    failed++;
                    $display("FAIL frame_wr px%0d: got we=%b row=%0d col=%0d, want 1 %0d %0d",
                             i, wr_en_o, wr_row_o, wr_col_o, r % L, c);
                end
            end
            if (i > 0) begin
                pr = (i-1) / W; pc = (i-1) % W;
                ptok = (pr >= K-1) && (pc >= K-1);
                tests_run++;
                if (valid_o !== ptok) begin
                    failed++;
                    $display("FAIL frame_valid px%0d: got %b want %b", i-1, valid_o, ptok);
                end
                if (ptok && valid_o === 1'b1) begin
                    ntok++;
                    if (first < 0) first = i-1;
                    tests_run++;
                    if (row_o !== RW'(pr) || col_o !== CW'(pc) || top_row_o !== PW'((pr - (K-1) + L) % L)) begin
                        failed++;
                        $display("FAIL frame_payload px%0d: got r=%0d c=%0d t=%0d, want %0d %0d %0d",
                                 i-1, row_o, col_o, top_row_o, pr, pc, (pr - (K-1) + L) % L);
                    end
                end
            end
            tests_run++;
            if (frame_done_o !== (i == W*H)) begin
                failed++;
                $display("FAIL frame_done cyc%0d: got %b want %b", i, frame_done_o, (i == W*H));
            end
            tick();
        end
        valid_i = 1'b0;
        #1;
        tests_run++;
        if (frame_done_o !== 1'b0 || valid_o !== 1'b0) begin
            failed++;
            $display("FAIL frame_tail: got fd=%b v=%b want 0 0", frame_done_o, valid_o);
        end
        tests_run++;
        if (ntok != 24 || first != 18) begin
            failed++;
            $display("FAIL frame_tokens: got count=%0d first=%0d want 24 18", ntok, first);
        end
    endtask

    task automatic test_stall();
        do_reset();
        for (int i = 0; i < 19; i++) begin
            valid_i = 1'b1; ready_i = 1'b1;
            tick();
        end
        for (int s = 0; s < 5; s++) begin
            valid_i = 1'b1; ready_i = 1'b0;
            #1;
            tests_run++;
            if (ready_o !== 1'b0 || wr_en_o !== 1'b0 || valid_o !== 1'b1 ||
                row_o !== RW'(2) || col_o !== CW'(2) || top_row_o !== PW'(0)) begin
                failed++;
                $display("FAIL stall_hold s%0d: got rdy=%b we=%b v=%b r=%0d c=%0d t=%0d, want 0 0 1 2 2 0",
                         s, ready_o, wr_en_o, valid_o, row_o, col_o, top_row_o);
            end
            tick();
        end
        valid_i = 1'b0; ready_i = 1'b1;
        #1;
        tests_run++;
        if (valid_o !== 1'b1 || ready_o !== 1'b1) begin
            failed++;
            $display("FAIL stall_release: got v=%b rdy=%b want 1 1", valid_o, ready_o);
        end
`ifdef LINE_WINDOW_STALL_CNT_EN
        tests_run++;
        if (stall_cnt !== 16'd5) begin
            failed++;
            $display("FAIL stall_cnt: got %0d want 5", stall_cnt);
        end
`endif
        tick();
        #1;
        tests_run++;
        if (valid_o !== 1'b0 || wr_col_o !== CW'(3) || wr_row_o !== PW'(2)) begin
            failed++;
            $display("FAIL stall_pop_idle: got v=%b col=%0d row=%0d want 0 3 2", valid_o, wr_col_o, wr_row_o);
        end
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        #1;
        tests_run++;
        if (valid_o !== 1'b1 || row_o !== RW'(2) || col_o !== CW'(3)) begin
            failed++;
            $display("FAIL stall_resume: got v=%b r=%0d c=%0d want 1 2 3", valid_o, row_o, col_o);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            valid_i = 1'b1; ready_i = 1'b1;
            tick();
        end
        reset_i = 1'b1; valid_i = 1'b1;
        tick();
        reset_i = 1'b0;
        #1;
        tests_run++;
        if (valid_o !== 1'b0 || frame_done_o !== 1'b0 || row_o !== '0 || col_o !== '0 || top_row_o !== '0 ||
            wr_en_o !== 1'b1 || wr_row_o !== '0 || wr_col_o !== '0) begin
            failed++;
            $display("FAIL midrst_clear: got v=%b fd=%b r=%0d c=%0d t=%0d we=%b wrow=%0d wcol=%0d, want 0 0 0 0 0 1 0 0",
                     valid_o, frame_done_o, row_o, col_o, top_row_o, wr_en_o, wr_row_o, wr_col_o);
        end
        tick();
        #1;
        tests_run++;
        if (valid_o !== 1'b0 || wr_col_o !== CW'(1) || wr_row_o !== '0) begin
            failed++;
            $display("FAIL midrst_fill: got v=%b col=%0d row=%0d want 0 1 0", valid_o, wr_col_o, wr_row_o);
        end
        for (int i = 1; i < 19; i++) tick();
        valid_i = 1'b0;
        #1;
        tests_run++;
        if (valid_o !== 1'b1 || row_o !== RW'(2) || col_o !== CW'(2) || top_row_o !== PW'(0)) begin
            failed++;
            $display("FAIL midrst_restart: got v=%b r=%0d c=%0d t=%0d want 1 2 2 0", valid_o, row_o, col_o, top_row_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] tok [2][$];
        int p, pr, pc;
        bit ptok;
        do_reset();
        for (int i = 0; i <= 2*W*H; i++) begin
            valid_i = (i < 2*W*H); ready_i = 1'b1;
            #1;
            if (i == W*H) begin
                tests_run++;
                if (wr_en_o !== 1'b1 || wr_row_o !== '0 || wr_col_o !== '0 || frame_done_o !== 1'b1) begin
                    failed++;
                    $display("FAIL b2b_boundary: got we=%b row=%0d col=%0d fd=%b want 1 0 0 1",
                             wr_en_o, wr_row_o, wr_col_o, frame_done_o);
                end
            end
            if (i == W*H + 1 || i == 2*W*H) begin
                tests_run++;
                if (frame_done_o !== (i == 2*W*H)) begin
                    failed++;
                    $display("FAIL b2b_done cyc%0d: got %b want %b", i, frame_done_o, (i == 2*W*H));
                end
            end
            if (i > 0) begin
                p = (i-1) % (W*H); pr = p / W; pc = p % W;
                ptok = (pr >= K-1) && (pc >= K-1);
                tests_run++;
                if (valid_o !== ptok) begin
                    failed++;
                    $display("FAIL b2b_valid cyc%0d: got %b want %b", i, valid_o, ptok);
                end
                if (valid_o === 1'b1) tok[(i-1) / (W*H)].push_back({row_o, col_o, top_row_o});
            end
            tick();
        end
        valid_i = 1'b0;
        tests_run++;
        if (tok[0].size() != 24 || tok[1].size() != 24) begin
            failed++;
            $display("FAIL b2b_count: got %0d/%0d want 24/24", tok[0].size(), tok[1].size());
        end else begin
            for (int j = 0; j < 24; j++) begin
                tests_run++;
                if (tok[1][j] !== tok[0][j]) begin
                    failed++;
                    $display("FAIL b2b_seq tok%0d: got %h want %h", j, tok[1][j], tok[0][j]);
                end
            end
        end
    endtask

    task automatic test_small();
        int ntok = 0, first = -1;
        int r, c, pr, pc;
        bit ptok;
        reset2 = 1'b1; valid2 = 1'b0; ready2 = 1'b1;
        tick(); tick();
        reset2 = 1'b0;
        for (int i = 0; i <= W2*H2; i++) begin
            valid2 = (i < W2*H2);
            #1;
            if (i < W2*H2) begin
                r = i / W2; c = i % W2;
                tests_run++;
                if (wr_en2_o !== 1'b1 || wr_row2_o !== PW2'(r % L2) || wr_col2_o !== CW2'(c)) begin
                    failed++;
                    $display("FAIL small_wr px%0d: got we=%b row=%0d col=%0d, want 1 %0d %0d",
                             i, wr_en2_o, wr_row2_o, wr_col2_o, r % L2, c);
                end
            end
            if (i > 0) begin
                pr = (i-1) / W2; pc = (i-1) % W2;
                ptok = (pr >= K2-1) && (pc >= K2-1);
                tests_run++;
                if (valid2_o !== ptok) begin
                    failed++;
                    $display("FAIL small_valid px%0d: got %b want %b", i-1, valid2_o, ptok);
                end
                if (ptok && valid2_o === 1'b1) begin
                    ntok++;
                    if (first < 0) first = i-1;
                    tests_run++;
                    if (row2_o !== RW2'(pr) || col2_o !== CW2'(pc) || top_row2_o !== PW2'((pr - (K2-1) + L2) % L2)) begin
                        failed++;
                        $display("FAIL small_payload px%0d: got r=%0d c=%0d t=%0d, want %0d %0d %0d",
                                 i-1, row2_o, col2_o, top_row2_o, pr, pc, (pr - (K2-1) + L2) % L2);
                    end
                end
            end
            tests_run++;
            if (frame_done2_o !== (i == W2*H2)) begin
                failed++;
                $display("FAIL small_done cyc%0d: got %b want %b", i, frame_done2_o, (i == W2*H2));
            end
            tick();
        end
        valid2 = 1'b0;
        tests_run++;
        if (ntok != 12 || first != 5) begin
            failed++;
            $display("FAIL small_tokens: got count=%0d first=%0d want 12 5", ntok, first);
        end
    endtask

    initial begin
        reset_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
        reset2  = 1'b1; valid2  = 1'b0; ready2  = 1'b1;
        tick();
        test_reset();
        test_frame();
        test_stall();
        test_mid_reset();
        test_back_to_back();
        test_small();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
